// File: rtl/grf_pkg.sv
// Shared defaults and FSM state encoding for the multiport general register file.
// Imported by the register file top and its pending-bit scoreboard.
package grf_pkg;
    localparam int DW_DEF   = 32;
    localparam int NREG_DEF = 32;
    localparam int NRP_DEF  = 2;
    localparam int NWP_DEF  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } grf_state_e;
endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending bits: writes clear, issue sets (issue beats write), sweep and reset clear.
// Updates one cycle after the request; no backpressure, the caller gates requests.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int NWP  = NWP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_v,
    input  logic [AW-1:0]     set_a,
    input  logic [NWP-1:0]    clr_v,
    input  logic [NWP*AW-1:0] clr_a,
    input  logic              sweep_v,
    input  logic [AW-1:0]     sweep_a,
    output logic [NREG-1:0]   pend
);
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        for (int w = 0; w < NWP; w++) begin
            if (clr_v[w]) pend_d[clr_a[w*AW +: AW]] = 1'b0;
        end
        // A newer producer issued in the same cycle as a write keeps the bit set.
        if (set_v) pend_d[set_a] = 1'b1;
        if (sweep_v) pend_d[sweep_a] = 1'b0;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign pend = pend_q;
endmodule

// File: rtl/grf_multiport.sv
// Multiport register file with write-through bypass, pending scoreboard and sweep-clear FSM.
// Reads are combinational, writes commit next edge; while sweeping all writes are refused (wr_ack=0).
module grf_multiport
    import grf_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int NRP  = NRP_DEF,
    parameter int NWP  = NWP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRP*AW-1:0] ra,
    output logic [NRP*DW-1:0] rd,
    output logic [NRP-1:0]    rpend,
    input  logic [NWP-1:0]    we,
    input  logic [NWP*AW-1:0] wa,
    input  logic [NWP*DW-1:0] wd,
    input  logic              iss_v,
    input  logic [AW-1:0]     iss_a,
    input  logic              clr_req,
    output logic              busy,
    output logic [NWP-1:0]    wr_ack
);
    grf_state_e      state_q;
    logic [AW-1:0]   cnt_q;
    logic [DW-1:0]   mem_q [NREG];
    logic [NREG-1:0] pend;
    logic            in_sweep;
    logic            iss_acc;
    logic [NWP-1:0]  wr_acc;
    logic [NRP-1:0]  hit;

    assign in_sweep = (state_q == SWEEP);
    assign busy     = in_sweep & ~reset;
    assign wr_ack   = {NWP{~busy}};
    assign wr_acc   = we & {NWP{~in_sweep & ~reset}};
    assign iss_acc  = iss_v & ~in_sweep & ~reset & (iss_a != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= AW'(1);
        end else begin
            case (state_q)
                IDLE: if (clr_req) state_q <= SWEEP;
                SWEEP: begin
                    if (cnt_q == AW'(NREG - 1)) begin
                        state_q <= IDLE;
                        cnt_q   <= AW'(1);
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Later ports are assigned last, so the highest-indexed writer wins a conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (in_sweep) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int w = 0; w < NWP; w++) begin
                if (wr_acc[w] && wa[w*AW +: AW] != '0)
                    mem_q[wa[w*AW +: AW]] <= wd[w*DW +: DW];
            end
        end
    end

    always_comb begin
        rd    = '0;
        rpend = '0;
        hit   = '0;
        for (int p = 0; p < NRP; p++) begin
            rd[p*DW +: DW] = mem_q[ra[p*AW +: AW]];
            for (int w = 0; w < NWP; w++) begin
                if (wr_acc[w] && wa[w*AW +: AW] == ra[p*AW +: AW] && ra[p*AW +: AW] != '0) begin
                    rd[p*DW +: DW] = wd[w*DW +: DW];
                    hit[p]         = 1'b1;
                end
            end
            rpend[p] = pend[ra[p*AW +: AW]] & ~hit[p];
        end
        if (in_sweep || reset) begin
            rd    = '0;
            rpend = '0;
        end
    end

    grf_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .NWP  (NWP)
    ) u_sb (
        .clk     (clk),
        .reset   (reset),
        .set_v   (iss_acc),
        .set_a   (iss_a),
        .clr_v   (wr_acc),
        .clr_a   (wa),
        .sweep_v (in_sweep),
        .sweep_a (cnt_q),
        .pend    (pend)
    );
endmodule

// File: tb/tb_grf_multiport.sv
// Directed bench for grf_multiport: bypass, conflicts, reg 0, scoreboard, sweep and reset mid-sweep.
module tb_grf_multiport;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rpend;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        iss_v;
    logic [4:0]  iss_a;
    logic        clr_req;
    logic        busy;
    logic [1:0]  wr_ack;

    int total = 0;
    int bad   = 0;
    int n;

    grf_multiport dut (
        .clk     (clk),
        .reset   (reset),
        .ra      (ra),
        .rd      (rd),
        .rpend   (rpend),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .iss_v   (iss_v),
        .iss_a   (iss_a),
        .clr_req (clr_req),
        .busy    (busy),
        .wr_ack  (wr_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ra = '0; we = '0; wa = '0; wd = '0;
        iss_v = 1'b0; iss_a = '0; clr_req = 1'b0;

        // Reset outputs, with a write attempted under reset
        step();
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEAD_BEEF}; ra = {5'd5, 5'd5};
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_ack", 64'(wr_ack), 64'd3);
        chk("rst_rd", rd, 64'd0);
        chk("rst_rpend", 64'(rpend), 64'd0);
        step();
        reset = 1'b0; we = '0;
        #1;
        chk("post_rst_rd", rd, 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Bypass on port 0
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'h1234_ABCD}; ra = {5'd0, 5'd5};
        #1;
        chk("byp_same", rd, {32'd0, 32'h1234_ABCD});
        chk("byp_ack", 64'(wr_ack), 64'd3);
        step();
        we = '0;
        #1;
        chk("byp_after", rd, {32'd0, 32'h1234_ABCD});

        // Two ports writing reg 7: port 1 wins
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11}; ra = {5'd7, 5'd7};
        #1;
        chk("conf_same", rd, {32'h22, 32'h22});
        chk("conf_ack", 64'(wr_ack), 64'd3);
        step();
        we = '0;
        #1;
        chk("conf_after", rd, {32'h22, 32'h22});

        // Register 0 ignores writes and issue
        we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'hFFFF_FFFF}; ra = {5'd0, 5'd0};
        iss_v = 1'b1; iss_a = 5'd0;
        #1;
        chk("r0_same", rd, 64'd0);
        chk("r0_ack", 64'(wr_ack), 64'd3);
        step();
        we = '0; iss_v = 1'b0;
        #1;
        chk("r0_rd", rd, 64'd0);
        chk("r0_rpend", 64'(rpend), 64'd0);

        // Scoreboard on reg 3
        iss_v = 1'b1; iss_a = 5'd3; ra = {5'd3, 5'd3};
        #1;
        chk("sb_iss_same", 64'(rpend), 64'd0);
        step();
        iss_v = 1'b0;
        #1;
        chk("sb_iss_next", 64'(rpend), 64'd3);
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h33}; iss_v = 1'b1; iss_a = 5'd3;
        #1;
        chk("sb_byp_rpend", 64'(rpend), 64'd0);
        chk("sb_byp_rd", rd, {32'h33, 32'h33});
        step();
        we = '0; iss_v = 1'b0;
        #1;
        chk("sb_wr_iss", 64'(rpend), 64'd3);
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h44};
        step();
        we = '0;
        #1;
        chk("sb_wr_only", 64'(rpend), 64'd0);
        chk("sb_wr_rd", rd, {32'h44, 32'h44});

        // Fill every register, mark reg 9 pending
        for (int i = 1; i < 32; i++) begin
            we = 2'b01; wa = {5'd0, 5'(i)}; wd = {32'd0, 32'hA000_0000 | i};
            step();
        end
        we = '0;
        iss_v = 1'b1; iss_a = 5'd9;
        step();
        iss_v = 1'b0; ra = {5'd31, 5'd1};
        #1;
        chk("fill_rd", rd, {32'hA000_001F, 32'hA000_0001});
        ra = {5'd9, 5'd9};
        #1;
        chk("fill_pend9", 64'(rpend), 64'd3);

        // Full sweep with writes, issue and clr_req attempted while busy
        clr_req = 1'b1;
        #1;
        chk("sw_req_busy", 64'(busy), 64'd0);
        step();
        clr_req = 1'b0;
        #1;
        chk("sw_busy", 64'(busy), 64'd1);
        we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'hDEAD, 32'hBEEF}; ra = {5'd5, 5'd9};
        iss_v = 1'b1; iss_a = 5'd12; clr_req = 1'b1;
        #1;
        chk("sw_ack", 64'(wr_ack), 64'd0);
        chk("sw_rd", rd, 64'd0);
        chk("sw_rpend", 64'(rpend), 64'd0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("sw_len", 64'(n), 64'd31);
        we = '0; iss_v = 1'b0; clr_req = 1'b0;
        step();
        chk("sw_idle", 64'(busy), 64'd0);
        for (int i = 0; i < 32; i++) begin
            ra = {5'(i), 5'(i)};
            #1;
            chk($sformatf("sw_clr_%0d", i), rd, 64'd0);
        end
        ra = {5'd12, 5'd9};
        #1;
        chk("sw_pend", 64'(rpend), 64'd0);

        // Reset at sweep cycle 10
        we = 2'b11; wa = {5'd25, 5'd20}; wd = {32'h2525, 32'h2020};
        step();
        we = '0; ra = {5'd25, 5'd20};
        #1;
        chk("rs_fill", rd, {32'h2525, 32'h2020});
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 1; i < 10; i++) step();
        chk("rs_busy10", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("rs_busy_in_rst", 64'(busy), 64'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rs_busy_after", 64'(busy), 64'd0);
        chk("rs_rd", rd, 64'd0);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("rs_sw_len", 64'(n), 64'd31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
